pipe_stage_skid: RTL and testbench

- Parametrised successor of the fixed memory/writeback pipeline latch.
- Carries NUM_VAL value channels plus instruction word, type and exception fields through one pipeline stage.
- Replaces the global block/flush wires with a valid/ready handshake and an optional two-entry skid buffer, so stalls need not propagate combinationally across the whole pipe.
- Adds sticky first-exception capture and a saturating stall counter for debug.

---
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - one pipeline stage with valid/ready handshake, optional skid entry, exception capture and stall counter
module pipe_stage_skid #(
    parameter int DATA_W  = 32,
    parameter int NUM_VAL = 2,
    parameter int IR_W    = 32,
    parameter int TYPE_W  = 2,
    parameter int EXC_W   = 3,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VAL*DATA_W-1:0] in_val,
    input  logic [IR_W-1:0]           in_ir,
    input  logic [TYPE_W-1:0]         in_type,
    input  logic [EXC_W-1:0]          in_exception,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_VAL*DATA_W-1:0] out_val,
    output logic [IR_W-1:0]           out_ir,
    output logic [TYPE_W-1:0]         out_type,
    output logic [EXC_W-1:0]          out_exception,
    input  logic                      exc_clear,
    output logic                      exc_seen,
    output logic [IR_W-1:0]           exc_ir,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int VW = NUM_VAL * DATA_W;
    localparam int BW = VW + IR_W + TYPE_W + EXC_W;

    logic [BW-1:0]    w_in_beat;
    logic [BW-1:0]    r_main;
    logic [BW-1:0]    r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_live;
    logic             r_exc_seen;
    logic [IR_W-1:0]  r_exc_ir;
    logic [CNT_W-1:0] r_stall;
    logic             w_emit;
    logic             w_accept;
    logic             w_main_free;
    logic             w_capture;

    // The whole beat travels as one packed word; fields are unpacked at the output.
    assign w_in_beat = {in_val, in_ir, in_type, in_exception};

    // With a skid entry, ready is a pure function of state so stalls stop here;
    // without it, ready looks through to out_ready in the same cycle.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = r_live & ~r_skid_valid;
        end else begin : g_ready_comb
            assign in_ready = r_live & (out_ready | ~r_main_valid);
        end
    endgenerate

    assign w_emit      = r_main_valid & out_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_main_free = ~r_main_valid | w_emit;
    assign w_capture   = w_emit & (out_exception != '0) & (~r_exc_seen | exc_clear);

    // Ready is held low for the reset cycle itself and comes back the cycle after release.
    always_ff @(posedge clock) begin
        r_live <= reset_n;
    end

    // Main/skid entries: skid drains into main first so beat order is preserved.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_in_beat;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept && (SKID != 0)) begin
            r_skid       <= w_in_beat;
            r_skid_valid <= 1'b1;
        end
    end

    // First leaving exception is latched; a capture in a clear cycle replaces the old word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_exc_seen <= 1'b0;
            r_exc_ir   <= '0;
        end else if (w_capture) begin
            r_exc_seen <= 1'b1;
            r_exc_ir   <= out_ir;
        end else if (exc_clear) begin
            r_exc_seen <= 1'b0;
            r_exc_ir   <= '0;
        end
    end

    // Saturating count of cycles where a beat waits on the consumer; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (r_main_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign out_valid     = r_main_valid;
    assign out_exception = r_main[EXC_W-1:0];
    assign out_type      = r_main[EXC_W +: TYPE_W];
    assign out_ir        = r_main[EXC_W+TYPE_W +: IR_W];
    assign out_val       = r_main[BW-1 -: VW];
    assign exc_seen      = r_exc_seen;
    assign exc_ir        = r_exc_ir;
    assign stall_count   = r_stall;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - bench for pipe_stage_skid, SKID=1 and SKID=0 side by side
module tb_pipe_stage_skid;

    localparam int CW = 8;

    typedef struct packed {
        logic [63:0] val;
        logic [31:0] ir;
        logic [1:0]  typ;
        logic [2:0]  exc;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] ir;
        logic        ordy;
        logic        rdy1;
        logic        rdy0;
        logic        ov1;
        logic [31:0] oir1;
        logic [7:0]  st1;
    } vec_t;

    logic  clock = 1'b0;
    logic  reset_n, flush, in_valid, out_ready, exc_clear;
    beat_t cur;

    logic        o1_in_ready, o1_valid, o1_seen;
    logic [63:0] o1_val;
    logic [31:0] o1_ir, o1_eir;
    logic [1:0]  o1_type;
    logic [2:0]  o1_exc;
    logic [7:0]  o1_stall;
    logic        o0_in_ready, o0_valid, o0_seen;
    logic [63:0] o0_val;
    logic [31:0] o0_ir, o0_eir;
    logic [1:0]  o0_type;
    logic [2:0]  o0_exc;
    logic [7:0]  o0_stall;

    always #5 clock = ~clock;

    pipe_stage_skid #(.SKID(1), .CNT_W(CW)) u_s1 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_val(cur.val), .in_ir(cur.ir), .in_type(cur.typ), .in_exception(cur.exc),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_val(o1_val), .out_ir(o1_ir), .out_type(o1_type), .out_exception(o1_exc),
        .exc_clear(exc_clear), .exc_seen(o1_seen), .exc_ir(o1_eir), .stall_count(o1_stall)
    );

    pipe_stage_skid #(.SKID(0), .CNT_W(CW)) u_s0 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_val(cur.val), .in_ir(cur.ir), .in_type(cur.typ), .in_exception(cur.exc),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_val(o0_val), .out_ir(o0_ir), .out_type(o0_type), .out_exception(o0_exc),
        .exc_clear(exc_clear), .exc_seen(o0_seen), .exc_ir(o0_eir), .stall_count(o0_stall)
    );

    // Reference model: index 0 = SKID=1 (capacity 2), index 1 = SKID=0 (capacity 1).
    beat_t       mq[2][$];
    logic        m_live[2];
    logic        m_seen[2];
    logic        m_zero[2];
    logic [31:0] m_eir[2];
    logic [7:0]  m_stall[2];
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        tbl[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_rdy(input int s);
        if (s == 0) return m_live[s] && (mq[s].size() < 2);
        return m_live[s] && (out_ready || (mq[s].size() == 0));
    endfunction

    task automatic model_step();
        for (int s = 0; s < 2; s++) begin
            if (!reset_n) begin
                mq[s].delete();
                m_live[s]  = 1'b0;
                m_seen[s]  = 1'b0;
                m_eir[s]   = '0;
                m_stall[s] = '0;
                m_zero[s]  = 1'b1;
            end else begin
                logic rdy, emit, acc;
                rdy  = m_rdy(s);
                emit = (mq[s].size() > 0) && out_ready;
                acc  = in_valid && rdy;
                if ((mq[s].size() > 0) && !out_ready && (m_stall[s] != 8'hFF)) m_stall[s]++;
                if (emit && (mq[s][0].exc != 0) && (!m_seen[s] || exc_clear)) begin
                    m_seen[s] = 1'b1;
                    m_eir[s]  = mq[s][0].ir;
                end else if (exc_clear) begin
                    m_seen[s] = 1'b0;
                    m_eir[s]  = '0;
                end
                if (flush) begin
                    mq[s].delete();
                    m_zero[s] = 1'b1;
                end else begin
                    if (emit) void'(mq[s].pop_front());
                    if (acc) begin
                        mq[s].push_back(cur);
                        m_zero[s] = 1'b0;
                    end
                end
                m_live[s] = 1'b1;
            end
        end
    endtask

    task automatic chk_inst(input int s, input logic ov, input logic [63:0] v, input logic [31:0] ir,
                            input logic [1:0] ty, input logic [2:0] ex, input logic sn,
                            input logic [31:0] eir, input logic [7:0] st);
        string p;
        p = (s == 0) ? "skid1" : "skid0";
        chk({p, ".out_valid"}, ov, mq[s].size() > 0);
        if (mq[s].size() > 0) begin
            chk({p, ".out_val"}, v, mq[s][0].val);
            chk({p, ".out_ir"}, ir, mq[s][0].ir);
            chk({p, ".out_type"}, ty, mq[s][0].typ);
            chk({p, ".out_exc"}, ex, mq[s][0].exc);
        end else if (m_zero[s]) begin
            chk({p, ".payload_zero"}, {v, ir, ty, ex}, '0);
        end
        chk({p, ".exc_seen"}, sn, m_seen[s]);
        chk({p, ".exc_ir"}, eir, m_eir[s]);
        chk({p, ".stall_count"}, st, m_stall[s]);
    endtask

    task automatic tick();
        #1;
        chk("skid1.in_ready", o1_in_ready, m_rdy(0));
        chk("skid0.in_ready", o0_in_ready, m_rdy(1));
        model_step();
        @(posedge clock);
        #1;
        chk_inst(0, o1_valid, o1_val, o1_ir, o1_type, o1_exc, o1_seen, o1_eir, o1_stall);
        chk_inst(1, o0_valid, o0_val, o0_ir, o0_type, o0_exc, o0_seen, o0_eir, o0_stall);
    endtask

    task automatic set_beat(input logic [31:0] ir, input logic [2:0] exc);
        cur.ir  = ir;
        cur.exc = exc;
        cur.typ = ir[1:0];
        cur.val = {ir ^ 32'hA5A5_0000, ~ir};
    endtask

    task automatic send(input logic [31:0] ir, input logic [2:0] exc);
        in_valid = 1'b1;
        set_beat(ir, exc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic add_vec(input int i, input logic iv, input logic [31:0] ir, input logic ordy,
                           input logic rdy1, input logic rdy0, input logic ov1,
                           input logic [31:0] oir1, input logic [7:0] st1);
        tbl[i].iv = iv;   tbl[i].ir = ir;     tbl[i].ordy = ordy;
        tbl[i].rdy1 = rdy1; tbl[i].rdy0 = rdy0; tbl[i].ov1 = ov1;
        tbl[i].oir1 = oir1; tbl[i].st1 = st1;
    endtask

    initial begin
        //          iv  ir     ordy rdy1 rdy0 ov1 oir1   st1
        add_vec(0,  1, 32'h10, 1,   1,   1,   1, 32'h10, 0);
        add_vec(1,  1, 32'h11, 1,   1,   1,   1, 32'h11, 0);
        add_vec(2,  1, 32'h12, 1,   1,   1,   1, 32'h12, 0);
        add_vec(3,  1, 32'h13, 1,   1,   1,   1, 32'h13, 0);
        add_vec(4,  0, 32'h00, 1,   1,   1,   0, 32'h00, 0);
        add_vec(5,  1, 32'h0A, 0,   1,   1,   1, 32'h0A, 0);
        add_vec(6,  1, 32'h0B, 0,   1,   0,   1, 32'h0A, 1);
        add_vec(7,  1, 32'h0C, 0,   0,   0,   1, 32'h0A, 2);
        add_vec(8,  1, 32'h0C, 1,   0,   1,   1, 32'h0B, 2);
        add_vec(9,  1, 32'h0C, 1,   1,   1,   1, 32'h0C, 2);
        add_vec(10, 0, 32'h00, 1,   1,   1,   0, 32'h00, 2);

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; exc_clear = 1'b0;
        set_beat(32'h0, 3'd0);
        model_step();
        @(posedge clock);
        #1;
        chk_inst(0, o1_valid, o1_val, o1_ir, o1_type, o1_exc, o1_seen, o1_eir, o1_stall);
        chk_inst(1, o0_valid, o0_val, o0_ir, o0_type, o0_exc, o0_seen, o0_eir, o0_stall);
        tick();
        chk("reset.in_ready_low", {o1_in_ready, o0_in_ready}, 2'b00);
        reset_n = 1'b1;
        tick();
        chk("release.in_ready_high", {o1_in_ready, o0_in_ready}, 2'b11);

        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            set_beat(tbl[i].ir, 3'd0);
            #1;
            chk($sformatf("vec%0d.rdy1", i), o1_in_ready, tbl[i].rdy1);
            chk($sformatf("vec%0d.rdy0", i), o0_in_ready, tbl[i].rdy0);
            tick();
            chk($sformatf("vec%0d.ov1", i), o1_valid, tbl[i].ov1);
            if (tbl[i].ov1) chk($sformatf("vec%0d.oir1", i), o1_ir, tbl[i].oir1);
            chk($sformatf("vec%0d.stall1", i), o1_stall, tbl[i].st1);
        end

        out_ready = 1'b1;
        send(32'h50, 3'b000);
        send(32'h55, 3'b010);
        send(32'h66, 3'b100);
        idle(2);
        chk("exc.first_seen", {o1_seen, o0_seen}, 2'b11);
        chk("exc.first_ir1", o1_eir, 32'h55);
        chk("exc.first_ir0", o0_eir, 32'h55);
        send(32'h77, 3'b001);
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        chk("exc.clear_capture_seen", {o1_seen, o0_seen}, 2'b11);
        chk("exc.clear_capture_ir", o1_eir, 32'h77);

        out_ready = 1'b0;
        send(32'h81, 3'd0);
        send(32'h82, 3'd0);
        chk("flush.pre_full_rdy", o1_in_ready, 1'b0);
        flush = 1'b1; in_valid = 1'b1; set_beat(32'h83, 3'd5);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", {o1_valid, o0_valid}, 2'b00);
        chk("flush.payload", {o1_val, o1_ir, o1_type, o1_exc}, '0);
        chk("flush.in_ready", o1_in_ready, 1'b1);
        chk("flush.exc_kept", {o1_seen, o1_eir}, {1'b1, 32'h77});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush.no_ghost", {o1_valid, o0_valid}, 2'b00);
        end
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        chk("exc.clear_only", {o1_seen, o1_eir}, '0);

        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        out_ready = 1'b0;
        send(32'h91, 3'd0);
        send(32'h92, 3'd0);
        idle(4);
        chk("midstall.stall5", o1_stall, 8'd5);
        chk("midstall.skid_full", o1_in_ready, 1'b0);
        reset_n = 1'b0;
        tick();
        chk("midstall.rst_outs", {o1_valid, o1_val, o1_ir, o1_type, o1_exc, o1_seen, o1_eir, o1_stall}, '0);
        chk("midstall.rst_rdy", {o1_in_ready, o0_in_ready}, 2'b00);
        reset_n = 1'b1;
        tick();
        chk("midstall.release_rdy", {o1_in_ready, o0_in_ready}, 2'b11);

        send(32'hA1, 3'd0);
        idle((1 << CW) + 3);
        chk("sat.stall1", o1_stall, 8'hFF);
        chk("sat.stall0", o0_stall, 8'hFF);
        out_ready = 1'b1;
        idle(2);

        for (int i = 0; i < 800; i++) begin
            reset_n   = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            exc_clear = ($urandom_range(0, 19) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cur.val   = {$urandom, $urandom};
            cur.ir    = $urandom;
            cur.typ   = 2'($urandom_range(0, 3));
            cur.exc   = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
